// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage definitions: occupancy state encodings reused by stall-capable stages.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Occupancy as a beat count; the encodings are chosen so this is an identity.
  function automatic logic [1:0] state_count(input skid_state_t st);
    return logic'(st == ST_FULL) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_en_reg.sv
// Falling-edge register with synchronous reset to INIT and a load enable.
module en_reg #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and flush.
import pipe_skid_reg_pkg::*;

module pipe_skid_reg #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             main_valid;
  logic             skid_valid;
  skid_state_t      state;
  skid_state_t      state_nxt;
  logic             accept;
  logic             drain;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  // The state is never stored separately; it is decoded from the two valid bits.
  always_comb begin
    state = ST_EMPTY;
    if (skid_valid) begin
      state = ST_FULL;
    end else if (main_valid) begin
      state = ST_ONE;
    end
  end

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = !rst && (state != ST_FULL);
  assign count     = state_count(state);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          main_en   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          skid_en   = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt      = ST_ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything held and any beat taken this cycle, without touching data.
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(negedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= (state_nxt != ST_EMPTY);
      skid_valid <= (state_nxt == ST_FULL);
    end
  end

  en_reg #(.WIDTH(WIDTH), .INIT(INIT)) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  en_reg #(.WIDTH(WIDTH), .INIT(INIT)) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a 32-bit instance with a boot-vector INIT and a 64-bit instance.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  int          n_checks = 0;
  int          n_fails  = 0;

  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .INIT(32'hBFC0_0000)) u_dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  pipe_skid_reg #(.WIDTH(64), .INIT(64'h0)) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one active (falling) edge; inputs changed afterwards are far from any edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] data, input logic valid,
                         input logic [1:0] cnt, input logic rdy);
    check({tag, ".data"},  64'(a_out_data),  64'(data));
    check({tag, ".valid"}, 64'(a_out_valid), 64'(valid));
    check({tag, ".count"}, 64'(a_count),     64'(cnt));
    check({tag, ".ready"}, 64'(a_in_ready),  64'(rdy));
  endtask

  task automatic push_a(input logic [31:0] d, input logic ordy);
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_out_ready = ordy;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset: a beat offered during reset must not be taken.
    tick();
    push_a(32'h1234, 1'b1);
    tick();
    check_a("reset", 32'hBFC0_0000, 1'b0, 2'd0, 1'b0);
    a_rst = 1'b0; b_rst = 1'b0; a_in_valid = 1'b0;
    #1;
    check("reset_release.ready", 64'(a_in_ready), 64'd1);

    // Streaming at one beat per clock.
    push_a(32'h1, 1'b1); tick();
    check_a("stream1", 32'h1, 1'b1, 2'd1, 1'b1);
    push_a(32'h2, 1'b1); tick();
    check_a("stream2", 32'h2, 1'b1, 2'd1, 1'b1);
    push_a(32'h3, 1'b1); tick();
    check_a("stream3", 32'h3, 1'b1, 2'd1, 1'b1);
    a_in_valid = 1'b0; tick();
    check_a("stream_end", 32'h3, 1'b0, 2'd0, 1'b1);

    // Backpressure fills the skid; a third offer is refused while full.
    push_a(32'hA, 1'b0); tick();
    check_a("bp_one", 32'hA, 1'b1, 2'd1, 1'b1);
    push_a(32'hB, 1'b0); tick();
    check_a("bp_full", 32'hA, 1'b1, 2'd2, 1'b0);
    push_a(32'hC, 1'b0); tick();
    check_a("bp_hold", 32'hA, 1'b1, 2'd2, 1'b0);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1;
    check("bp_drain0.data", 64'(a_out_data), 64'hA);
    tick();
    check_a("bp_drain1", 32'hB, 1'b1, 2'd1, 1'b1);
    tick();
    check_a("bp_drain2", 32'hB, 1'b0, 2'd0, 1'b1);

    // Simultaneous accept and drain in ONE.
    push_a(32'h5, 1'b0); tick();
    check_a("sim_one", 32'h5, 1'b1, 2'd1, 1'b1);
    push_a(32'h6, 1'b1); tick();
    check_a("sim_swap", 32'h6, 1'b1, 2'd1, 1'b1);
    a_in_valid = 1'b0; tick();
    check_a("sim_end", 32'h6, 1'b0, 2'd0, 1'b1);

    // Flush from FULL with a beat offered: nothing survives, data registers untouched.
    a_out_ready = 1'b0;
    push_a(32'h7, 1'b0); tick();
    push_a(32'h8, 1'b0); tick();
    check_a("fl_full", 32'h7, 1'b1, 2'd2, 1'b0);
    push_a(32'h9, 1'b0); a_flush = 1'b1; tick();
    check_a("fl_full_after", 32'h7, 1'b0, 2'd0, 1'b1);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
    check_a("fl_quiet", 32'h7, 1'b0, 2'd0, 1'b1);

    // Flush in ONE with an accept: the accepted beat is discarded, main is not rewritten.
    push_a(32'h10, 1'b0); tick();
    push_a(32'h11, 1'b0); a_flush = 1'b1; tick();
    check_a("fl_one_after", 32'h10, 1'b0, 2'd0, 1'b1);
    a_flush = 1'b0; a_in_valid = 1'b0; tick();
    check_a("fl_one_quiet", 32'h10, 1'b0, 2'd0, 1'b1);

    // Mid-stream reset drops held beats and restores INIT.
    push_a(32'h21, 1'b0); tick();
    push_a(32'h22, 1'b0); tick();
    check_a("mr_full", 32'h21, 1'b1, 2'd2, 1'b0);
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_rst = 1'b1; tick();
    check_a("mr_reset", 32'hBFC0_0000, 1'b0, 2'd0, 1'b0);
    a_rst = 1'b0; tick();
    check_a("mr_after", 32'hBFC0_0000, 1'b0, 2'd0, 1'b1);

    // 64-bit instance: backpressure with a full-width payload.
    check("w64_reset.data", b_out_data, 64'h0);
    b_in_valid = 1'b1; b_in_data = 64'hDEAD_BEEF_CAFE_F00D; b_out_ready = 1'b0; tick();
    check("w64_one.data",  b_out_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("w64_one.count", 64'(b_count), 64'd1);
    b_in_data = 64'h0123_4567_89AB_CDEF; tick();
    check("w64_full.count", 64'(b_count), 64'd2);
    check("w64_full.ready", 64'(b_in_ready), 64'd0);
    check("w64_full.data",  b_out_data, 64'hDEAD_BEEF_CAFE_F00D);
    b_in_valid = 1'b0; b_out_ready = 1'b1; tick();
    check("w64_drain1.data",  b_out_data, 64'h0123_4567_89AB_CDEF);
    check("w64_drain1.count", 64'(b_count), 64'd1);
    tick();
    check("w64_drain2.valid", 64'(b_out_valid), 64'd0);
    check("w64_drain2.count", 64'(b_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
